// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, load FSM encoding and clog2 helper.
package uart_pkg;
  localparam int MIDI_BAUD = 31_250;
  localparam int SYS_CLK_HZ = 50_000_000;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ACK = 2'd2} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: pointer-based FIFO; level and empty lag the pointers by one cycle, full does not.
module sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic                      full,
  output logic                      empty,
  output logic [clog2(DEPTH):0]     level,
  output logic [WIDTH-1:0]          dout
);
  localparam int AW = clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, level_q, level_d;
  logic empty_q, empty_d, do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_comb begin
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push && !full;
    do_pop = pop && (wr_q != rd_q);
    wr_d = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = do_pop ? rd_q + (AW+1)'(1) : rd_q;
    level_d = wr_q - rd_q;
    empty_d = wr_q == rd_q;
    empty = empty_q;
    level = level_q;
    dout = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      empty_q <= empty_d;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: queues bytes for the UART transmitter, issues load strobes and the baud shift strobe.
module uart_tx_feeder import uart_pkg::*; #(
  parameter int CLK_HZ = SYS_CLK_HZ,
  parameter int BAUD = MIDI_BAUD,
  parameter int DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [clog2(DEPTH):0] level,
  input  logic                  tx_full,
  output logic [7:0]            tx_din,
  output logic                  tx_load,
  output logic                  tx_shift
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = clog2(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic shift_q, shift_d, full, empty;
  logic [7:0] head, din_q, din_d;
  state_e state_q, state_d;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(in_valid && in_ready), .pop(tx_load),
    .din(in_data), .full(full), .empty(empty), .level(level), .dout(head)
  );
  always_comb begin
    cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
    shift_d = cnt_q == CW'(DIV - 1);
    // ACK is a fixed dead cycle: the transmitter raises tx_full one clock after a load
    state_d = (state_q == IDLE) ? ((!empty && !tx_full) ? LOAD : IDLE) :
              (state_q == LOAD) ? ACK : IDLE;
    din_d = (state_d == LOAD) ? head : din_q;
    in_ready = !full;
    tx_load = state_q == LOAD;
    tx_din = din_q;
    tx_shift = shift_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      shift_q <= 1'b0;
      state_q <= IDLE;
      din_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      state_q <= state_d;
      din_q <= din_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed scoreboard bench for uart_tx_feeder.
module tb_uart_tx_feeder;
  localparam int DIV = 1600;
  logic clock, reset, in_valid, in_ready, tx_full, tx_load, tx_shift;
  logic [7:0] in_data, tx_din;
  logic [4:0] level;
  logic model_en, model_full, manual_full;
  int model_cnt, loads, checks, errors;
  logic [7:0] exp_q [$];

  assign tx_full = model_en ? model_full : manual_full;

  uart_tx_feeder dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .level(level), .tx_full(tx_full), .tx_din(tx_din),
    .tx_load(tx_load), .tx_shift(tx_shift)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic ld, pu;
    logic [7:0] pd;
    ld = tx_load;
    pu = in_valid && in_ready && !reset;
    pd = in_data;
    @(posedge clock);
    #1;
    if (pu) exp_q.push_back(pd);
    if (model_en) begin
      if (ld) begin
        model_full = 1'b1;
        model_cnt = 5;
      end else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) model_full = 1'b0;
      end
    end
    if (tx_load) begin
      loads++;
      if (model_en) chk("load_while_full", tx_full, 0);
      if (exp_q.size() == 0) chk("unexpected_load", 1, 0);
      else chk("tx_din", tx_din, exp_q.pop_front());
    end
  endtask

  task automatic wait_load(input string tag);
    int n;
    n = 0;
    while (!tx_load && n < 40) begin
      tick();
      n++;
    end
    chk(tag, tx_load, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = base + 8'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; loads = 0; model_cnt = 0;
    model_en = 1'b0; model_full = 1'b0; manual_full = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tx_load", tx_load, 0);
    chk("rst_tx_din", tx_din, 8'h00);
    chk("rst_tx_shift", tx_shift, 0);
    reset = 1'b0;
    for (int i = 1; i <= 4000; i++) begin
      tick();
      chk("t1_shift", tx_shift, (i == DIV) || (i == 2 * DIV));
      chk("t1_load", tx_load, 0);
    end
    chk("t1_level", level, 0);
    chk("t1_in_ready", in_ready, 1);

    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("t2_load_early0", tx_load, 0);
    tick();
    chk("t2_load_early1", tx_load, 0);
    chk("t2_level1", level, 1);
    tick();
    chk("t2_load", tx_load, 1);
    chk("t2_din", tx_din, 8'hA5);
    tick();
    chk("t2_load_one_cycle", tx_load, 0);
    chk("t2_din_hold", tx_din, 8'hA5);
    repeat (3) tick();
    chk("t2_level0", level, 0);

    manual_full = 1'b1;
    fill(16, 8'h00);
    in_valid = 1'b1; in_data = 8'h10;
    chk("t3_ready_full", in_ready, 0);
    repeat (2) tick();
    chk("t3_level16", level, 16);
    chk("t3_ready0", in_ready, 0);
    in_valid = 1'b0;
    manual_full = 1'b0;
    wait_load("t3_first_load_seen");
    chk("t3_first_byte", tx_din, 8'h00);
    for (int n = 0; n < 80 && exp_q.size() > 0; n++) tick();
    chk("t3_drained", exp_q.size(), 0);
    repeat (4) tick();
    chk("t3_level0", level, 0);

    model_en = 1'b1; model_full = 1'b0; model_cnt = 0; loads = 0;
    fill(3, 8'h30);
    repeat (60) tick();
    chk("t4_loads", loads, 3);
    chk("t4_sb_empty", exp_q.size(), 0);
    model_en = 1'b0;

    do_reset();
    manual_full = 1'b1;
    fill(16, 8'h50);
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (2) tick();
    chk("t5_level16", level, 16);
    manual_full = 1'b0;
    wait_load("t5_load_seen");
    chk("t5_ready_in_load", in_ready, 0);
    manual_full = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("t5_level15", level, 15);

    do_reset();
    manual_full = 1'b1;
    fill(8, 8'h60);
    repeat (2) tick();
    chk("t5_level8", level, 8);
    manual_full = 1'b0;
    wait_load("t5b_load_seen");
    in_valid = 1'b1; in_data = 8'hC3;
    manual_full = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("t5_level8_kept", level, 8);
    chk("t5_no_double_load", tx_load, 0);

    do_reset();
    manual_full = 1'b1;
    fill(5, 8'h70);
    repeat (2) tick();
    chk("t6_level5", level, 5);
    manual_full = 1'b0;
    wait_load("t6_load_seen");
    reset = 1'b1;
    tick();
    chk("t6_load", tx_load, 0);
    chk("t6_level", level, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_shift", tx_shift, 0);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= DIV; i++) begin
      tick();
      chk("t6_shift_phase", tx_shift, i == DIV);
    end
    chk("t6_no_loads", tx_load, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
